fetch_load_sequencer: RTL and testbench

Controller in front of `fetch_unit_v1_0_S00_AXIS` that sequences one compute job end to end.

- Takes a job descriptor (matrix A, matrix B and instruction lengths/widths).
- Drives `bram_sel`/`row_width` into the fetch unit for each load phase.
- Gates the inbound AXI-Stream so beats reach the fetch unit only in the correct phase, and counts beats against expected lengths.
- Pulses the PE array start and waits for completion, flagging framing errors.

---
 rtl/fetch_pkg.sv | 32 +++
 rtl/fetch_load_sequencer_if.sv | 32 +++
 rtl/stream_beat_counter.sv | 37 +++
 rtl/fetch_load_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_fetch_load_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and codes for the fetch load sequencer: FSM states, BRAM
// select codes, error codes and the descriptor length check.
package fetch_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_SET_A  = 4'd1,
        ST_LOAD_A = 4'd2,
        ST_SET_B  = 4'd3,
        ST_LOAD_B = 4'd4,
        ST_SET_I  = 4'd5,
        ST_LOAD_I = 4'd6,
        ST_START  = 4'd7,
        ST_RUN    = 4'd8,
        ST_ERR    = 4'd9
    } state_t;

    localparam logic [1:0] SEL_MAT_A = 2'd0;
    localparam logic [1:0] SEL_MAT_B = 2'd1;
    localparam logic [1:0] SEL_INSTR = 2'd2;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_SHORT  = 2'd1;
    localparam logic [1:0] ERR_LONG   = 2'd2;
    localparam logic [1:0] ERR_BADLEN = 2'd3;

    // A length is unusable when it is zero or larger than the target BRAM
    function automatic logic len_bad(input logic [15:0] len, input logic [15:0] max_len);
        return (len == 16'd0) || (len > max_len);
    endfunction

endpackage

// File: rtl/fetch_load_sequencer_if.sv
// Job descriptor handshake plus the gated AXI-Stream path between the
// upstream source and the fetch unit.
interface fetch_load_sequencer_if #(
    parameter int BRAM_DEPTH       = 10,
    parameter int INSTR_BRAM_DEPTH = 11
) ();
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [BRAM_DEPTH:0]       cmd_a_len;
    logic [31:0]               cmd_a_width;
    logic [BRAM_DEPTH:0]       cmd_b_len;
    logic [31:0]               cmd_b_width;
    logic [INSTR_BRAM_DEPTH:0] cmd_i_len;
    logic                      cmd_skip_instr;
    logic                      up_tvalid;
    logic                      up_tlast;
    logic                      up_tready;
    logic                      fu_tvalid;
    logic                      fu_tready;

    modport slave (
        input  cmd_valid, cmd_a_len, cmd_a_width, cmd_b_len, cmd_b_width,
               cmd_i_len, cmd_skip_instr, up_tvalid, up_tlast, fu_tready,
        output cmd_ready, up_tready, fu_tvalid
    );

    modport master (
        output cmd_valid, cmd_a_len, cmd_a_width, cmd_b_len, cmd_b_width,
               cmd_i_len, cmd_skip_instr, up_tvalid, up_tlast, fu_tready,
        input  cmd_ready, up_tready, fu_tvalid
    );
endinterface

// File: rtl/stream_beat_counter.sv
// Counts accepted beats of one load phase and classifies the frame end
// against the expected length (complete / short / long).
module stream_beat_counter #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             beat,
    input  logic             last,
    input  logic [WIDTH-1:0] len,
    output logic             complete,
    output logic             short,
    output logic             long
);
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_inc_s;
    logic             at_len_s;

    assign count_inc_s = count_r + {{(WIDTH-1){1'b0}}, 1'b1};
    assign at_len_s    = (count_inc_s == len);

    // beat counter, cleared while the phase is being set up
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clear) begin
            count_r <= {WIDTH{1'b0}};
        end else if (beat) begin
            count_r <= count_inc_s;
        end
    end

    assign complete = beat & last & at_len_s;
    assign short    = beat & last & ~at_len_s;
    assign long     = beat & ~last & at_len_s;
endmodule

// File: rtl/fetch_load_sequencer.sv
// Sequences one compute job: loads A, B and optionally the program into the
// fetch unit through a gated stream, then starts the PE array and waits.
module fetch_load_sequencer
    import fetch_pkg::*;
#(
    parameter int BRAM_DEPTH       = 10,
    parameter int INSTR_BRAM_DEPTH = 11
) (
    input  logic                S_AXIS_ACLK,
    input  logic                S_AXIS_ARESET,
    fetch_load_sequencer_if.slave bus,
    output logic [1:0]          bram_sel,
    output logic [31:0]         row_width,
    output logic                pe_start,
    input  logic                pe_done,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code,
    input  logic                err_clr
);
    localparam int CNT_W = INSTR_BRAM_DEPTH + 1;

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic [1:0]                err_nxt_s;
    logic [BRAM_DEPTH:0]       a_len_r;
    logic [BRAM_DEPTH:0]       b_len_r;
    logic [INSTR_BRAM_DEPTH:0] i_len_r;
    logic [31:0]               b_width_r;
    logic                      skip_r;
    logic [1:0]                sel_r;
    logic [31:0]               width_r;
    logic                      pe_start_r;
    logic                      done_r;
    logic                      err_r;
    logic [1:0]                err_code_r;
    logic                      gate_open_s;
    logic                      beat_s;
    logic                      clear_s;
    logic                      cmd_bad_s;
    logic [CNT_W-1:0]          len_s;
    logic                      cnt_complete_s;
    logic                      cnt_short_s;
    logic                      cnt_long_s;

    assign gate_open_s = (state_r == ST_LOAD_A) || (state_r == ST_LOAD_B) || (state_r == ST_LOAD_I);
    assign clear_s     = (state_r == ST_SET_A) || (state_r == ST_SET_B) || (state_r == ST_SET_I);
    assign beat_s      = bus.up_tvalid & bus.fu_tready & gate_open_s;

    assign bus.up_tready = bus.fu_tready & gate_open_s;
    assign bus.fu_tvalid = bus.up_tvalid & gate_open_s;
    assign bus.cmd_ready = (state_r == ST_IDLE);
    assign busy          = (state_r != ST_IDLE);
    assign bram_sel      = sel_r;
    assign row_width     = width_r;
    assign pe_start      = pe_start_r;
    assign done          = done_r;
    assign err           = err_r;
    assign err_code      = err_code_r;

    // The instruction length is irrelevant when the resident program is reused
    assign cmd_bad_s = len_bad(16'(bus.cmd_a_len), 16'd1 << BRAM_DEPTH)
                     | len_bad(16'(bus.cmd_b_len), 16'd1 << BRAM_DEPTH)
                     | (~bus.cmd_skip_instr & len_bad(16'(bus.cmd_i_len), 16'd1 << INSTR_BRAM_DEPTH));

    // expected length of the phase currently loading
    always_comb begin
        len_s = CNT_W'(i_len_r);
        case (state_r)
            ST_LOAD_A: len_s = CNT_W'(a_len_r);
            ST_LOAD_B: len_s = CNT_W'(b_len_r);
            default:   len_s = CNT_W'(i_len_r);
        endcase
    end

    stream_beat_counter #(.WIDTH(CNT_W)) u_counter (
        .clk      (S_AXIS_ACLK),
        .rst      (S_AXIS_ARESET),
        .clear    (clear_s),
        .beat     (beat_s),
        .last     (bus.up_tlast),
        .len      (len_s),
        .complete (cnt_complete_s),
        .short    (cnt_short_s),
        .long     (cnt_long_s)
    );

    // next-state and error-code selection
    always_comb begin
        state_nxt_s = state_r;
        err_nxt_s   = ERR_NONE;
        case (state_r)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    if (cmd_bad_s) begin
                        state_nxt_s = ST_ERR;
                        err_nxt_s   = ERR_BADLEN;
                    end else begin
                        state_nxt_s = ST_SET_A;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SET_A: state_nxt_s = ST_LOAD_A;
            ST_SET_B: state_nxt_s = ST_LOAD_B;
            ST_SET_I: state_nxt_s = ST_LOAD_I;
            ST_LOAD_A, ST_LOAD_B, ST_LOAD_I: begin
                if (cnt_long_s) begin
                    state_nxt_s = ST_ERR;
                    err_nxt_s   = ERR_LONG;
                end else if (cnt_short_s) begin
                    state_nxt_s = ST_ERR;
                    err_nxt_s   = ERR_SHORT;
                end else if (cnt_complete_s) begin
                    if (state_r == ST_LOAD_A) begin
                        state_nxt_s = ST_SET_B;
                    end else if ((state_r == ST_LOAD_B) && !skip_r) begin
                        state_nxt_s = ST_SET_I;
                    end else begin
                        state_nxt_s = ST_START;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_START: state_nxt_s = ST_RUN;
            ST_RUN: begin
                if (pe_done) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_ERR: begin
                if (err_clr) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ERR;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // descriptor capture at the IDLE handshake
    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            a_len_r   <= '0;
            b_len_r   <= '0;
            i_len_r   <= '0;
            b_width_r <= 32'd0;
            skip_r    <= 1'b0;
        end else if ((state_r == ST_IDLE) && bus.cmd_valid) begin
            a_len_r   <= bus.cmd_a_len;
            b_len_r   <= bus.cmd_b_len;
            i_len_r   <= bus.cmd_i_len;
            b_width_r <= bus.cmd_b_width;
            skip_r    <= bus.cmd_skip_instr;
        end
    end

    // Phase config changes on entry to SET so it is stable a full cycle before the gate opens
    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            sel_r   <= SEL_MAT_A;
            width_r <= 32'd0;
        end else begin
            case (state_nxt_s)
                ST_SET_A: begin
                    sel_r   <= SEL_MAT_A;
                    width_r <= bus.cmd_a_width;
                end
                ST_SET_B: begin
                    sel_r   <= SEL_MAT_B;
                    width_r <= b_width_r;
                end
                ST_SET_I: begin
                    sel_r   <= SEL_INSTR;
                    width_r <= 32'd0;
                end
                default: begin
                    sel_r   <= sel_r;
                    width_r <= width_r;
                end
            endcase
        end
    end

    // start/done pulses and the sticky error
    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            pe_start_r <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= ERR_NONE;
        end else begin
            pe_start_r <= (state_nxt_s == ST_START);
            done_r     <= (state_r == ST_RUN) & pe_done;
            if (state_r == ST_ERR) begin
                if (err_clr) begin
                    err_r      <= 1'b0;
                    err_code_r <= ERR_NONE;
                end
            end else if (state_nxt_s == ST_ERR) begin
                err_r      <= 1'b1;
                err_code_r <= err_nxt_s;
            end
        end
    end
endmodule

// File: tb/tb_fetch_load_sequencer.sv
// Randomized scoreboard bench: a job-level model predicts the beat/start/
// done/error event stream, and a monitor compares what the DUT produces.
module tb_fetch_load_sequencer;
    import fetch_pkg::*;

    localparam int EV_BEAT  = 1;
    localparam int EV_START = 2;
    localparam int EV_DONE  = 3;
    localparam int EV_ERR   = 4;

    typedef struct {
        int          kind;
        int          a;
        logic [31:0] b;
    } ev_t;

    typedef struct {
        int          a_len;
        int          b_len;
        int          i_len;
        logic [31:0] a_w;
        logic [31:0] b_w;
        bit          skip;
        int          la;
        int          lb;
        int          li;
        int          bp_phase;
    } job_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pe_done = 1'b0;
    logic        err_clr = 1'b0;
    logic [1:0]  bram_sel;
    logic [31:0] row_width;
    logic        pe_start;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    bit  mon_en = 1'b0;
    logic err_q = 1'b0;
    int  cyc = 0;
    int  pl_n[3];
    int  pl_last[3];
    int  pl_cnt;
    int  outcome;

    fetch_load_sequencer_if #(.BRAM_DEPTH(10), .INSTR_BRAM_DEPTH(11)) bus ();

    fetch_load_sequencer #(.BRAM_DEPTH(10), .INSTR_BRAM_DEPTH(11)) dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESET (rst),
        .bus           (bus),
        .bram_sel      (bram_sel),
        .row_width     (row_width),
        .pe_start      (pe_start),
        .pe_done       (pe_done),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .err_code      (err_code),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_event(input int kind, input int a, input logic [31:0] b);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL event_unexpected: got kind %0d a %0d b %0h, expected nothing", kind, a, b);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.a != a || e.b !== b) begin
                n_err++;
                $display("FAIL event: got kind %0d a %0d b %0h expected kind %0d a %0d b %0h",
                         kind, a, b, e.kind, e.a, e.b);
            end
        end
    endtask

    function automatic void push(input int kind, input int a, input logic [31:0] b);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        exp_q.push_back(e);
    endfunction

    // monitor: sample mid-cycle, the handshake seen here completes on the next rising edge
    always @(negedge clk) begin
        #3;
        if (mon_en && !rst) begin
            if (bus.up_tvalid && bus.up_tready) chk_event(EV_BEAT, int'(bram_sel), row_width);
            if (pe_start) chk_event(EV_START, 0, 32'd0);
            if (done) chk_event(EV_DONE, 0, 32'd0);
            if (err && !err_q) chk_event(EV_ERR, int'(err_code), 32'd0);
        end
        err_q <= err;
    end

    // job-level reference: phases A, B, (I) each take min(tlast position, length) beats
    task automatic model_job(input job_t j);
        int          lens[3];
        int          lasts[3];
        logic [31:0] ws[3];
        int          n;
        lens  = '{j.a_len, j.b_len, j.i_len};
        lasts = '{j.la, j.lb, j.li};
        ws    = '{j.a_w, j.b_w, 32'd0};
        pl_cnt  = 0;
        outcome = 0;
        if (j.a_len < 1 || j.a_len > 1024 || j.b_len < 1 || j.b_len > 1024 ||
            (!j.skip && (j.i_len < 1 || j.i_len > 2048))) begin
            push(EV_ERR, 3, 32'd0);
            outcome = 3;
            return;
        end
        for (int p = 0; p < (j.skip ? 2 : 3); p++) begin
            n = (lasts[p] > 0 && lasts[p] <= lens[p]) ? lasts[p] : lens[p];
            pl_n[p]    = n;
            pl_last[p] = lasts[p];
            pl_cnt++;
            for (int k = 0; k < n; k++) push(EV_BEAT, p, ws[p]);
            if (lasts[p] != lens[p]) begin
                outcome = (lasts[p] > 0 && lasts[p] < lens[p]) ? 1 : 2;
                push(EV_ERR, outcome, 32'd0);
                return;
            end
        end
        push(EV_START, 0, 32'd0);
        push(EV_DONE, 0, 32'd0);
    endtask

    task automatic send_beats(input int n, input int last_pos, input bit bp);
        int guard;
        bit hs;
        for (int k = 1; k <= n; k++) begin
            hs    = 1'b0;
            guard = 0;
            while (!hs) begin
                @(negedge clk);
                cyc++;
                bus.fu_tready = bp ? (((cyc / 3) % 2) == 0) : ($urandom_range(0, 3) != 0);
                bus.up_tvalid = ($urandom_range(0, 4) != 0);
                bus.up_tlast  = (k == last_pos);
                #1;
                if (!bus.fu_tready) check("up_tready_follows_fu", bus.up_tready, 1'b0);
                hs = bus.up_tvalid && bus.up_tready;
                guard++;
                if (!hs && guard > 400) begin
                    n_err++;
                    $display("FAIL beat_timeout: beat %0d of %0d not accepted, required within 400 cycles", k, n);
                    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
                    $fatal(1, "stream stalled");
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic run_job(input job_t j);
        int g;
        model_job(j);
        @(negedge clk);
        bus.cmd_valid      = 1'b1;
        bus.cmd_a_len      = 11'(j.a_len);
        bus.cmd_a_width    = j.a_w;
        bus.cmd_b_len      = 11'(j.b_len);
        bus.cmd_b_width    = j.b_w;
        bus.cmd_i_len      = 12'(j.i_len);
        bus.cmd_skip_instr = j.skip;
        bus.up_tvalid      = 1'b0;
        bus.fu_tready      = 1'b1;
        pe_done            = 1'($urandom_range(0, 1));
        #1 check("cmd_ready_idle", bus.cmd_ready, 1'b1);
        @(negedge clk);
        bus.cmd_valid   = 1'b0;
        bus.cmd_a_width = $urandom;
        bus.cmd_b_width = $urandom;
        bus.cmd_b_len   = 11'($urandom);
        pe_done         = 1'b0;
        #1;
        if (outcome == 3) begin
            bus.up_tvalid = 1'b1;
            repeat (4) begin
                @(negedge clk);
                #1 check("gate_closed_badlen", bus.up_tready, 1'b0);
            end
        end else begin
            check("sel_after_accept", bram_sel, SEL_MAT_A);
            check("width_after_accept", row_width, j.a_w);
            check("gate_closed_in_set", bus.up_tready, 1'b0);
            check("busy_after_accept", busy, 1'b1);
            for (int p = 0; p < pl_cnt; p++) send_beats(pl_n[p], pl_last[p], p == j.bp_phase);
        end
        if (outcome == 0) begin
            @(negedge clk);
            bus.up_tvalid = 1'b0;
            #1 check("pe_start_after_last", pe_start, 1'b1);
            g = $urandom_range(0, 4);
            repeat (g) @(negedge clk);
            @(negedge clk);
            pe_done = 1'b1;
            @(negedge clk);
            pe_done = 1'b0;
            #1;
            check("done_pulse", done, 1'b1);
            check("busy_with_done", busy, 1'b0);
            check("cmd_ready_after_done", bus.cmd_ready, 1'b1);
            drain();
        end else begin
            if (outcome != 3) begin
                @(negedge clk);
                bus.up_tvalid = 1'b1;
                bus.up_tlast  = 1'b0;
                bus.fu_tready = 1'b1;
                #1;
                check("err_after_beat", err, 1'b1);
                check("err_code_after_beat", err_code, outcome);
                repeat (3) begin
                    check("gate_closed_in_err", bus.up_tready, 1'b0);
                    @(negedge clk);
                    #1;
                end
            end
            drain();
            @(negedge clk);
            bus.up_tvalid = 1'b0;
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            #1;
            check("cmd_ready_after_clr", bus.cmd_ready, 1'b1);
            check("err_after_clr", err, 1'b0);
            check("err_code_after_clr", err_code, 2'd0);
            check("busy_after_clr", busy, 1'b0);
        end
        bus.up_tvalid = 1'b0;
    endtask

    function automatic job_t mk(input int a, input logic [31:0] aw, input int b, input logic [31:0] bw,
                                input int i, input bit skip, input int la, input int lb, input int li,
                                input int bp);
        job_t j;
        j.a_len = a; j.a_w = aw; j.b_len = b; j.b_w = bw; j.i_len = i; j.skip = skip;
        j.la = la; j.lb = lb; j.li = li; j.bp_phase = bp;
        return j;
    endfunction

    function automatic int pick_last(input int len);
        int r = $urandom_range(0, 9);
        if (r < 7) return len;
        if (r == 7) return 0;
        if (r == 8) return $urandom_range(1, len);
        return len + 1;
    endfunction

    initial begin
        #900000;
        n_err++;
        $display("FAIL watchdog: simulation still running, required to finish before 90000 cycles");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        job_t j;
        bus.cmd_valid = 1'b0; bus.cmd_a_len = '0; bus.cmd_a_width = 32'd0; bus.cmd_b_len = '0;
        bus.cmd_b_width = 32'd0; bus.cmd_i_len = '0; bus.cmd_skip_instr = 1'b0;
        bus.up_tvalid = 1'b0; bus.up_tlast = 1'b0; bus.fu_tready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_cmd_ready", bus.cmd_ready, 1'b1);
        check("rst_up_tready", bus.up_tready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_bram_sel", bram_sel, 2'd0);
        check("rst_row_width", row_width, 32'd0);
        check("rst_pe_start", pe_start, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", {err, err_code}, 3'd0);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        run_job(mk(16, 32'd2, 15, 32'd5, 15, 1'b0, 16, 15, 15, 1));
        run_job(mk(16, 32'd3, 4, 32'd4, 4, 1'b0, 10, 4, 4, -1));
        run_job(mk(4, 32'd6, 15, 32'd8, 4, 1'b0, 4, 0, 4, -1));
        run_job(mk(5, 32'd11, 7, 32'd12, 0, 1'b1, 5, 7, 0, -1));
        run_job(mk(0, 32'd1, 4, 32'd1, 4, 1'b0, 0, 4, 4, -1));
        run_job(mk(3, 32'd1, 1025, 32'd1, 4, 1'b0, 3, 1025, 4, -1));
        run_job(mk(3, 32'd1, 2, 32'd1, 2049, 1'b0, 3, 2, 2049, -1));
        run_job(mk(3, 32'd1, 2, 32'd1, 0, 1'b0, 3, 2, 0, -1));
        run_job(mk(1024, 32'hdeadbeef, 1, 32'd5, 2048, 1'b0, 1024, 1, 2048, -1));

        // asynchronous reset in the middle of the B load
        mon_en = 1'b0;
        exp_q.delete();
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_a_len = 11'd4; bus.cmd_a_width = 32'd7;
        bus.cmd_b_len = 11'd10; bus.cmd_b_width = 32'd9; bus.cmd_i_len = 12'd3;
        bus.cmd_skip_instr = 1'b0; bus.fu_tready = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        send_beats(4, 4, 1'b0);
        send_beats(3, 0, 1'b0);
        @(negedge clk);
        bus.up_tvalid = 1'b1;
        bus.fu_tready = 1'b1;
        #1;
        check("in_load_b_sel", bram_sel, SEL_MAT_B);
        check("in_load_b_ready", bus.up_tready, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_up_tready", bus.up_tready, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_bram_sel", bram_sel, 2'd0);
        check("async_rst_row_width", row_width, 32'd0);
        check("async_rst_cmd_ready", bus.cmd_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        bus.up_tvalid = 1'b0;
        mon_en = 1'b1;
        run_job(mk(16, 32'd2, 15, 32'd5, 15, 1'b0, 16, 15, 15, -1));

        for (int r = 0; r < 25; r++) begin
            j.a_len = $urandom_range(1, 12);
            j.b_len = $urandom_range(1, 12);
            j.i_len = $urandom_range(1, 12);
            j.a_w   = $urandom;
            j.b_w   = $urandom;
            j.skip  = 1'($urandom_range(0, 1));
            j.la    = pick_last(j.a_len);
            j.lb    = pick_last(j.b_len);
            j.li    = pick_last(j.i_len);
            j.bp_phase = $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) j.b_len = ($urandom_range(0, 1) == 0) ? 0 : 1025;
            run_job(j);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
